// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the
// divided-clock measurement stage.
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    HIGH,
    LOW,
    DONE
  } state_e;

  localparam int unsigned WD_MULT = 3;
  localparam int unsigned WD_OFFS = 4;

  function automatic int unsigned exp_hi(
    input int unsigned n
  );
    return n >> 1;
  endfunction

  function automatic int unsigned exp_lo(
    input int unsigned n
  );
    return n - (n >> 1);
  endfunction

  function automatic int unsigned wd_limit(
    input int unsigned n
  );
    return WD_MULT * n + WD_OFFS;
  endfunction

endpackage

// File: rtl/clk_div_monitor_edge.sv
// clk_edge_det: samples a slow signal on clk and flags
// rise/fall. Ports: clk, rst_n, sig_i -> rise_o, fall_o.
module clk_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic clk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_q <= 1'b0;
    else        clk_q <= sig_i;
  end

  assign rise_o = sig_i & ~clk_q;
  assign fall_o = ~sig_i & clk_q;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures one period of clk_in in clk_ref
// cycles after start; reports counts and pass/bypass/timeout.
module clk_div_monitor #(
  parameter int div_ratio_wd = 8
) (
  input  logic                  clk_ref,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [div_ratio_wd-1:0] div_ratio,
  input  logic                  clk_in,
  output logic                  busy,
  output logic                  done,
  output logic [div_ratio_wd-1:0] hi_cnt,
  output logic [div_ratio_wd-1:0] lo_cnt,
  output logic [div_ratio_wd:0] period,
  output logic                  pass,
  output logic                  bypass,
  output logic                  timeout
);

  import clk_div_pkg::*;

  localparam int W   = div_ratio_wd;
  localparam int WDW = div_ratio_wd + 2;

  state_e         state_q;
  logic [W-1:0]   n_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_d;
  logic [WDW-1:0] wd_lim;
  logic           to_q;
  logic           byp_q;
  logic           expired;
  logic           hi_ok;
  logic           lo_ok;
  logic           rise;
  logic           fall;

  logic           busy_q;
  logic           done_q;
  logic           pass_q;
  logic           bypass_q;
  logic           timeout_q;
  logic [W-1:0]   hi_cnt_q;
  logic [W-1:0]   lo_cnt_q;
  logic [W:0]     period_q;

  clk_edge_det u_edge (
    .clk    (clk_ref),
    .rst_n  (rst_n),
    .sig_i  (clk_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  function automatic logic [W-1:0] sat_inc(
    input logic [W-1:0] v
  );
    return (&v) ? v : v + W'(1);
  endfunction

  assign wd_d    = wd_q + WDW'(1);
  assign wd_lim  = WDW'(wd_limit(32'(n_q)));
  assign expired = (wd_d >= wd_lim);
  assign hi_ok   = (hi_q == W'(exp_hi(32'(n_q))));
  assign lo_ok   = (lo_q == W'(exp_lo(32'(n_q))));

  // An edge in the expiry cycle takes priority; the
  // >= compare still catches expiry on a later cycle.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wd_q      <= '0;
      to_q      <= 1'b0;
      byp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      bypass_q  <= 1'b0;
      timeout_q <= 1'b0;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      period_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            n_q    <= div_ratio;
            wd_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            to_q   <= 1'b0;
            busy_q <= 1'b1;
            if (div_ratio < W'(2)) begin
              byp_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              byp_q   <= 1'b0;
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          wd_q <= wd_d;
          if (rise) begin
            hi_q    <= W'(1);
            state_q <= HIGH;
          end else if (expired) begin
            to_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        HIGH: begin
          wd_q <= wd_d;
          if (fall) begin
            lo_q    <= W'(1);
            state_q <= LOW;
          end else begin
            if (clk_in) hi_q <= sat_inc(hi_q);
            if (expired) begin
              to_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        LOW: begin
          wd_q <= wd_d;
          if (rise) begin
            state_q <= DONE;
          end else begin
            if (!clk_in) lo_q <= sat_inc(lo_q);
            if (expired) begin
              to_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          hi_cnt_q  <= hi_q;
          lo_cnt_q  <= lo_q;
          period_q  <= {1'b0, hi_q} + {1'b0, lo_q};
          bypass_q  <= byp_q;
          timeout_q <= to_q;
          pass_q    <= ~to_q & ~byp_q
                     & hi_ok & lo_ok;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi_cnt  = hi_cnt_q;
  assign lo_cnt  = lo_cnt_q;
  assign period  = period_q;
  assign pass    = pass_q;
  assign bypass  = bypass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: behavioural divider drives
// clk_in; expected results queued at start, checked at done.
module tb_clk_div_monitor;

  localparam int W = 8;

  logic         clk_ref = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] div_ratio = '0;
  logic         clk_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_cnt;
  logic [W-1:0] lo_cnt;
  logic [W:0]   period;
  logic         pass;
  logic         bypass;
  logic         timeout;

  clk_div_monitor #(.div_ratio_wd(W)) dut (
    .clk_ref   (clk_ref),
    .rst_n     (rst_n),
    .start     (start),
    .div_ratio (div_ratio),
    .clk_in    (clk_in),
    .busy      (busy),
    .done      (done),
    .hi_cnt    (hi_cnt),
    .lo_cnt    (lo_cnt),
    .period    (period),
    .pass      (pass),
    .bypass    (bypass),
    .timeout   (timeout)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    string tag;
    int    hi;
    int    lo;
    int    per;
    int    ps;
    int    byp;
    int    to;
    int    lat;
    int    lat_max;
    int    t0;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   lat;
  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;

  int   div_n = 4;
  bit   div_en = 1'b0;
  bit   stuck_val = 1'b0;
  int   dcnt = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  always @(posedge clk_ref) cyc++;

  // Behavioural divider: high for n>>1, low for the rest.
  always @(posedge clk_ref) begin
    #1;
    if (div_en) begin
      dcnt   = (dcnt + 1 >= div_n) ? 0 : dcnt + 1;
      clk_in = (dcnt < div_n / 2);
    end else begin
      clk_in = stuck_val;
    end
  end

  always @(posedge clk_ref) begin
    #1;
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e   = sb.pop_front();
        lat = cyc - e.t0;
        chk({e.tag, ".hi"}, 32'(hi_cnt), e.hi);
        chk({e.tag, ".lo"}, 32'(lo_cnt), e.lo);
        chk({e.tag, ".period"}, 32'(period), e.per);
        chk({e.tag, ".pass"}, 32'(pass), e.ps);
        chk({e.tag, ".bypass"}, 32'(bypass), e.byp);
        chk({e.tag, ".timeout"}, 32'(timeout), e.to);
        if (e.lat >= 0)
          chk({e.tag, ".lat"}, lat, e.lat);
        else
          chk({e.tag, ".lat_le_max"},
              32'(lat <= e.lat_max), 1);
      end
    end
  end

  function automatic exp_t mk_meas(
    input string tag, input int n, input int act
  );
    exp_t r;
    r.tag     = tag;
    r.hi      = act >> 1;
    r.lo      = act - (act >> 1);
    r.per     = act;
    r.ps      = (r.hi == (n >> 1) &&
                 r.lo == n - (n >> 1)) ? 1 : 0;
    r.byp     = 0;
    r.to      = 0;
    r.lat     = -1;
    r.lat_max = 3 * n + 6;
    r.t0      = 0;
    return r;
  endfunction

  function automatic exp_t mk_fixed(
    input string tag, input int byp,
    input int to, input int lat
  );
    exp_t r;
    r.tag     = tag;
    r.hi      = 0;
    r.lo      = 0;
    r.per     = 0;
    r.ps      = 0;
    r.byp     = byp;
    r.to      = to;
    r.lat     = lat;
    r.lat_max = lat;
    r.t0      = 0;
    return r;
  endfunction

  task automatic issue(input exp_t x, input int n);
    @(posedge clk_ref);
    #1;
    x.t0 = cyc;
    sb.push_back(x);
    div_ratio = W'(n);
    start     = 1'b1;
    @(posedge clk_ref);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk_ref);
      k++;
    end
    #2;
    chk({tag, ".completed"}, 32'(sb.size() == 0), 1);
    sb.delete();
  endtask

  task automatic set_div(input int n);
    div_n  = n;
    div_en = 1'b1;
    repeat (20) @(posedge clk_ref);
  endtask

  initial begin
    int   k;
    logic prev;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.hi", 32'(hi_cnt), 0);
    chk("rst.lo", 32'(lo_cnt), 0);
    chk("rst.period", 32'(period), 0);
    chk("rst.flags", {pass, bypass, timeout}, 0);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk_ref);

    set_div(4);
    issue(mk_meas("n4", 4, 4), 4);
    repeat (2) @(posedge clk_ref);
    #1;
    div_ratio = '0;
    start     = 1'b1;
    @(posedge clk_ref);
    #1;
    start = 1'b0;
    chk("start_while_busy.busy", 32'(busy), 1);
    wait_idle("n4");

    set_div(5);
    issue(mk_meas("n5", 5, 5), 5);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk_ref);
      #1;
      k++;
    end
    chk("n5.done_seen", 32'(done), 1);
    div_ratio = '0;
    start     = 1'b1;
    @(posedge clk_ref);
    #1;
    start = 1'b0;
    chk("start_in_done.busy", 32'(busy), 0);
    repeat (4) @(posedge clk_ref);
    #1;
    chk("start_in_done.idle", 32'(busy), 0);
    wait_idle("n5");

    issue(mk_fixed("byp0", 1, 0, 2), 0);
    wait_idle("byp0");
    issue(mk_fixed("byp1", 1, 0, 2), 1);
    wait_idle("byp1");

    div_en    = 1'b0;
    stuck_val = 1'b0;
    repeat (3) @(posedge clk_ref);
    issue(mk_fixed("stuck0", 0, 1, 18), 4);
    wait_idle("stuck0");

    stuck_val = 1'b1;
    repeat (3) @(posedge clk_ref);
    issue(mk_fixed("stuck1", 0, 1, 15), 3);
    wait_idle("stuck1");

    set_div(6);
    issue(mk_meas("n6_vs4", 4, 6), 4);
    wait_idle("n6_vs4");

    set_div(8);
    @(posedge clk_ref);
    #1;
    div_ratio = W'(8);
    start     = 1'b1;
    @(posedge clk_ref);
    #1;
    start = 1'b0;
    #1;
    prev = clk_in;
    k    = 0;
    forever begin
      @(posedge clk_ref);
      #2;
      k++;
      if ((clk_in && !prev) || k > 40) break;
      prev = clk_in;
    end
    chk("abort.rise_found", 32'(k <= 40), 1);
    @(posedge clk_ref);
    @(posedge clk_ref);
    #2;
    chk("abort.busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.hi", 32'(hi_cnt), 0);
    chk("abort.period", 32'(period), 0);
    chk("abort.flags", {done, pass, timeout}, 0);
    #4 rst_n = 1'b1;
    repeat (30) @(posedge clk_ref);
    issue(mk_meas("n8", 8, 8), 8);
    wait_idle("n8");

    repeat (5) @(posedge clk_ref);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1);
  end

endmodule
